shift_add_mult: RTL and testbench

Iterative shift-and-add unsigned multiplier for the mult_8bit datapath. It processes one multiplier bit per clock through a single WIDTH*2-bit accumulate adder. It trades latency for area against the combinational array built from half/full-adder cells. Operands come in and results go out over valid/ready handshakes, so it drops between an operand source and a result consumer.

---
 rtl/shift_add_mult.sv | 94 +++++++++
 tb/tb_shift_add_mult.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - iterative shift-and-add unsigned multiplier with valid/ready handshakes
// Optional early exit on an exhausted multiplier: define SHIFT_ADD_MULT_EARLY_TERM_EN.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last_iter;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // Stop once no set bits remain above the one consumed this edge.
  assign last_iter = (count == LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (count == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
            product  <= '0;
            count    <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (mplier[0]) begin
            product <= product + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_iter) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result stays put under backpressure; accepting operands waits for IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed self-checking bench for shift_add_mult
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  shift_add_mult #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] bv);
    int h;
    h = 0;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    for (int i = 0; i < 8; i++) if (bv[i]) h = i + 1;
    if (h < 1) h = 1;
`else
    h = 8;
`endif
    return h;
  endfunction

  // Present operands, wait for the accept edge, then count edges until out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input bit keep, output int lat);
    int n;
    logic rdy;
    logic [15:0] e;
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    n = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) break;
      if (n > 40) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = 16'(ta) * 16'(tbv);
    check("latency", 32'(lat), 32'(exp_lat(tbv)));
    check("product", 32'(product), 32'(e));
  endtask

  initial begin
    int lat;
    int prev_acc;
    logic [7:0] prev_b;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b0;

    // 13 * 11 with the handshake back to IDLE
    run_op(8'd13, 8'd11, 1'b0, lat);
    check("p143", 32'(product), 32'h008F);
    check("done_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_out_valid", 32'(out_valid), 32'd0);

    run_op(8'hFF, 8'hFF, 1'b0, lat);
    check("max_product", 32'(product), 32'hFE01);
    @(posedge clk);
    #1;
    run_op(8'h00, 8'hA5, 1'b0, lat);
    @(posedge clk);
    #1;

    // Backpressure: result held, new operands ignored
    out_ready = 1'b0;
    run_op(8'd7, 8'd9, 1'b0, lat);
    a = 8'd1;
    b = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'h003F);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_retained_product", 32'(product), 32'h003F);

    // Reset in the middle of an operation
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    run_op(8'd3, 8'd5, 1'b0, lat);
    check("after_abort", 32'(product), 32'd15);
    @(posedge clk);
    #1;

    // Edge operands for multiplier length
    run_op(8'hAB, 8'h00, 1'b0, lat);
    @(posedge clk);
    #1;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("ff_x1", 32'(product), 32'h00FF);
    @(posedge clk);
    #1;
    run_op(8'd3, 8'h80, 1'b0, lat);
    check("3_x80", 32'(product), 32'h0180);
    @(posedge clk);
    #1;

    // Back-to-back random operands with out_ready tied high
    prev_acc = 0;
    prev_b = '0;
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 1'b1, lat);
      if (i > 0) check("spacing", 32'(acc_cyc - prev_acc), 32'(exp_lat(prev_b) + 2));
      prev_acc = acc_cyc;
      prev_b = rb;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
